// File: rtl/fifo_rr_arbiter.sv
// Round-robin push arbiter and flush sequencer in front of one shared FIFO.
// Tracks FIFO occupancy locally so pushes never hit a full FIFO and pops never underflow.
module fifo_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       cons_pop,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       fifo_push,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic                       fifo_pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(NREQ-1);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic          pop;
  logic          underflow;
  logic [CW-1:0] count_next;

  // Rotating priority search starting at ptr; the pop input is deliberately
  // not consulted so a slot freed this cycle is only reusable next cycle.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (!rst && state == RUN && count != FULL) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!gnt_any && req[PW'(idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
  end

  assign gnt          = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign fifo_push    = gnt_any;
  assign fifo_data_in = gnt_any ? req_data[int'(gnt_idx)*WIDTH +: WIDTH] : '0;

  always_comb begin
    pop       = 1'b0;
    underflow = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          pop       = cons_pop && (count != '0);
          underflow = cons_pop && (count == '0);
        end
        FLUSH:   pop = (count != '0);
        default: pop = 1'b0;
      endcase
    end
  end

  assign fifo_pop = pop;

  always_comb begin
    case ({fifo_push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Drain completion looks at post-pop occupancy, so the last pop and the
  // move to DONE land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      ptr        <= '0;
      count      <= '0;
      err        <= 1'b0;
      flush_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      count <= count_next;
      if (gnt_any) ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      if (underflow) err <= 1'b1;
      case (state)
        RUN: begin
          if (flush) begin
            state <= FLUSH;
            busy  <= 1'b1;
          end
        end
        FLUSH: begin
          if (count_next == '0) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= RUN;
          flush_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: arbitration order, full/empty edges,
// flush sequencing and asynchronous reset, all against hand-computed values.
module tb_fifo_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int NREQ  = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  cons_pop;
  logic                  flush;
  logic                  flush_done;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data_in;
  logic                  fifo_pop;
  logic [CW-1:0]         count;
  logic                  busy;
  logic                  err;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .cons_pop(cons_pop), .flush(flush), .flush_done(flush_done),
    .fifo_push(fifo_push), .fifo_data_in(fifo_data_in), .fifo_pop(fifo_pop),
    .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Puts the DUT back to its reset state and releases on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; cons_pop = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b1111; cons_pop = 1'b1; flush = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (fifo_push !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_push: got %b expected 0", fifo_push); end
    n_cmp++; if (fifo_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pop: got %b expected 0", fifo_pop); end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush_done: got %b expected 0", flush_done); end
    @(negedge clk);
    rst = 1'b0; req = '0; cons_pop = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]  exp_g;
    logic [WIDTH-1:0] exp_d;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req = 4'b1111;
      exp_g = 4'b0001 << (c % 4);
      exp_d = 8'h11 * WIDTH'((c % 4) + 1);
      #1;
      n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("[TB] FAIL rr_gnt c=%0d: got %b expected %b", c, gnt, exp_g); end
      n_cmp++; if (fifo_data_in !== exp_d) begin n_fail++; $display("[TB] FAIL rr_data c=%0d: got %h expected %h", c, fifo_data_in, exp_d); end
      @(posedge clk); #1;
      n_cmp++; if (count !== CW'(c + 1)) begin n_fail++; $display("[TB] FAIL rr_count c=%0d: got %0d expected %0d", c, count, c + 1); end
    end
    @(negedge clk); #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL rr_full_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (fifo_push !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_full_push: got %b expected 0", fifo_push); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL rr_full_count: got %0d expected 8", count); end
  endtask

  task automatic test_full_boundary();
    @(negedge clk);
    req = 4'b0001; cons_pop = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL full_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (fifo_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL full_pop: got %b expected 1", fifo_pop); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd7) begin n_fail++; $display("[TB] FAIL full_count7: got %0d expected 7", count); end
    @(negedge clk);
    cons_pop = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL full_regrant: got %b expected 0001", gnt); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL full_count8: got %0d expected 8", count); end
  endtask

  task automatic test_skip_idle();
    logic [NREQ-1:0]  exp_g;
    logic [WIDTH-1:0] exp_d;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = 4'b1010;
      cons_pop = (c != 0);
      exp_g = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      exp_d = (c % 2 == 0) ? 8'h22 : 8'h44;
      #1;
      n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("[TB] FAIL skip_gnt c=%0d: got %b expected %b", c, gnt, exp_g); end
      n_cmp++; if (fifo_data_in !== exp_d) begin n_fail++; $display("[TB] FAIL skip_data c=%0d: got %h expected %h", c, fifo_data_in, exp_d); end
      n_cmp++; if (fifo_pop !== (c != 0)) begin n_fail++; $display("[TB] FAIL skip_pop c=%0d: got %b expected %b", c, fifo_pop, c != 0); end
      @(posedge clk); #1;
      n_cmp++; if (count !== 4'd1) begin n_fail++; $display("[TB] FAIL skip_count c=%0d: got %0d expected 1", c, count); end
    end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL skip_err: got %b expected 0", err); end
    @(negedge clk);
    req = '0; cons_pop = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    @(negedge clk);
    cons_pop = 1'b1;
    #1;
    n_cmp++; if (fifo_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_pop: got %b expected 0", fifo_pop); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_err_set: got %b expected 1", err); end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL uf_count: got %0d expected 0", count); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      cons_pop = 1'b0; req = 4'b0001;
      @(posedge clk); #1;
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_err_sticky c=%0d: got %b expected 1", c, err); end
    end
    @(negedge clk);
    req = '0; rst = 1'b1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_err_clear: got %b expected 0", err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = 4'b0001;
      @(posedge clk);
    end
    @(negedge clk);
    req = '0; flush = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd3) begin n_fail++; $display("[TB] FAIL fl_count_start: got %0d expected 3", count); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_busy: got %b expected 1", busy); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      flush = 1'b0; req = 4'b1111; cons_pop = (c == 1);
      #1;
      n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL fl_gnt c=%0d: got %b expected 0000", c, gnt); end
      n_cmp++; if (fifo_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_pop c=%0d: got %b expected 1", c, fifo_pop); end
      @(posedge clk); #1;
      n_cmp++; if (count !== CW'(2 - c)) begin n_fail++; $display("[TB] FAIL fl_count c=%0d: got %0d expected %0d", c, count, 2 - c); end
      n_cmp++; if (flush_done !== (c == 2)) begin n_fail++; $display("[TB] FAIL fl_done c=%0d: got %b expected %b", c, flush_done, c == 2); end
    end
    @(negedge clk);
    cons_pop = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL fl_done_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (fifo_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_done_pop: got %b expected 0", fifo_pop); end
    @(posedge clk); #1;
    n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_done_once: got %b expected 0", flush_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_busy_clear: got %b expected 0", busy); end
    @(negedge clk); #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL fl_resume_gnt: got %b expected 0010", gnt); end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_flush_with_grant();
    do_reset();
    @(negedge clk);
    req = 4'b0100; flush = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL fg_gnt: got %b expected 0100", gnt); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd1) begin n_fail++; $display("[TB] FAIL fg_count: got %0d expected 1", count); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL fg_gnt_blocked: got %b expected 0000", gnt); end
    n_cmp++; if (fifo_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL fg_pop: got %b expected 1", fifo_pop); end
    @(posedge clk); #1;
    n_cmp++; if (flush_done !== 1'b1) begin n_fail++; $display("[TB] FAIL fg_done: got %b expected 1", flush_done); end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL fg_count_end: got %0d expected 0", count); end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_flush_empty();
    do_reset();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("[TB] FAIL fe_done_early: got %b expected 0", flush_done); end
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (flush_done !== 1'b1) begin n_fail++; $display("[TB] FAIL fe_done: got %b expected 1", flush_done); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL fe_busy: got %b expected 0", busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req = 4'b0001;
      @(posedge clk);
    end
    @(negedge clk);
    req = '0; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; req = 4'b1111;
    #1;
    n_cmp++; if (fifo_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_pre_pop: got %b expected 1", fifo_pop); end
    n_cmp++; if (count !== 4'd5) begin n_fail++; $display("[TB] FAIL ar_pre_count: got %0d expected 5", count); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_busy: got %b expected 0", busy); end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL ar_count: got %0d expected 0", count); end
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL ar_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (fifo_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_pop: got %b expected 0", fifo_pop); end
    @(negedge clk);
    rst = 1'b0; req = 4'b0100;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL ar_regrant: got %b expected 0100", gnt); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd1) begin n_fail++; $display("[TB] FAIL ar_count_after: got %0d expected 1", count); end
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; cons_pop = 1'b0; flush = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    test_reset();
    test_round_robin();
    test_full_boundary();
    test_skip_idle();
    test_underflow();
    test_flush();
    test_flush_with_grant();
    test_flush_empty();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin push arbiter and flush sequencer for a single shared circular-pointer FIFO.
- NREQ producers each present req plus data. The block grants at most one producer per cycle and drives the FIFO push port. It forwards the consumer pop and tracks occupancy itself, so full is never violated.
- A flush request drains the FIFO to empty before producers are re-admitted.
- Sits between the producers/consumer and the FIFO instance; the FIFO shares clk and rst.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 8, FIFO capacity in entries; must match the attached FIFO.
- NREQ, 4, number of producers; must be 2 or more.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- req  input  NREQ  per-producer push request.
- req_data  input  NREQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, combinational; transfer occurs when req[i] && gnt[i].
- cons_pop  input  1  consumer pop request.
- flush  input  1  single-cycle flush request.
- flush_done  output  1  registered; single-cycle pulse when drain completes.
- fifo_push  output  1  push to FIFO.
- fifo_data_in  output  WIDTH  data to FIFO.
- fifo_pop  output  1  pop to FIFO.
- count  output  $clog2(DEPTH+1)  registered occupancy.
- busy  output  1  high when state != RUN.
- err  output  1  sticky; set on consumer pop while empty.

Behaviour:
- Reset (async, rst=1): state=RUN, rr pointer ptr=0, count=0, err=0, flush_done=0. With rst=1: gnt=0, fifo_push=0, fifo_pop=0.
- States: RUN, FLUSH, DONE.
  - RUN -> FLUSH on flush=1.
  - FLUSH -> DONE when count==0 at the clock edge, after any pop that cycle.
  - DONE -> RUN after one cycle.
  - flush is ignored outside RUN.
- Grant (RUN only, count<DEPTH):
  - Search req starting at index ptr, wrapping modulo NREQ; first set bit wins.
  - No grant if req==0, state!=RUN, or count==DEPTH.
  - A simultaneous consumer pop does not free a slot in the same cycle: no push-on-full.
- On grant to i: ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- fifo_push = |gnt. fifo_data_in = req_data slice of the granted index; all zeros when no grant.
- Pop:
  - In RUN, fifo_pop = cons_pop && count>0.
  - cons_pop && count==0 sets err, and the pop is not forwarded.
  - In FLUSH, fifo_pop = (count>0) and cons_pop is ignored.
  - In DONE, fifo_pop=0.
- count update: count <= count + push - pop, using the forwarded push/pop only. It never exceeds DEPTH and never goes below 0.
- Push and pop in the same cycle: count unchanged; both forwarded.
- flush in the same cycle as a grant: that grant and push complete. FLUSH begins next cycle and drains that entry too.
- flush with count==0: RUN -> FLUSH -> DONE, so flush_done pulses 2 cycles after flush.
- flush_done = 1 exactly while state==DONE. busy = (state!=RUN).
- err clears only on reset.
- Reset mid-FLUSH aborts immediately to RUN with count=0. The FIFO must be reset in the same cycle.
- gnt/fifo_push are combinational from req, state, count and ptr. No combinational path from cons_pop to gnt.

Test Plan:
- Round-robin fairness: NREQ=4, req=4'b1111 held 8 cycles, no pops from reset → grants 0,1,2,3,0,1,2,3; count reaches DEPTH=8 at cycle 8; gnt=0 afterwards.
- Skip idle requesters: ptr=0, req=4'b1010 for 4 cycles with pop each cycle → grants 1,3,1,3; count stays 1 after the first cycle; fifo_data_in matches the granted slice.
- Full boundary: count=8, req=4'b0001 and cons_pop=1 same cycle → gnt=0, fifo_pop=1, count=7. The next cycle grants 0 and count=8.
- Flush: count=3, flush pulse with req=4'b1111 held → no grants for 4 cycles; fifo_pop high 3 cycles; flush_done pulses once; grants resume the cycle after flush_done.
- Underflow: from reset, cons_pop=1 → fifo_pop=0, err=1 next cycle and stays 1 until rst.
- Async reset mid-flush: assert rst between clock edges while in FLUSH with count=5 → immediately busy=0, count=0, gnt=0, fifo_pop=0; after release, req=4'b0100 is granted on the first edge.
